// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier: FSM encoding,
// default operand width and the iteration-counter width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_W = 8;

  // The counter must hold 0..w (w+1 iterations).
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational N-bit adder/subtractor used for the Booth partial-product step.
module booth_addsub #(
  parameter int N = 10
) (
  input  logic         sub,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] sum
);

  always_comb begin
    sum = sub ? (x - y) : (x + y);
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with fixed W+1 iteration latency,
// signed or unsigned operands selected per operation.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           ready,
  output logic           done
);

  localparam int CW = cnt_w(W);

  // Handshake: an operation is accepted on a rising edge where start=1 and
  // ready=1; done is high for exactly the one DONE cycle, when product is new.
  state_e         state_q, state_d;
  logic [W+1:0]   acc_q, acc_d;
  logic [W:0]     mq_q, mq_d;
  logic           qm1_q, qm1_d;
  logic [W:0]     mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] product_q, product_d;

  logic           accept;
  logic           op_add, op_sub;
  logic [W+1:0]   sum;
  logic [W+1:0]   acc_new;
  logic [W:0]     ext_a, ext_b;

  assign ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign accept  = start && ready;

  assign ext_a  = signed_mode ? {a[W-1], a} : {1'b0, a};
  assign ext_b  = signed_mode ? {b[W-1], b} : {1'b0, b};
  assign op_add = ({mq_q[0], qm1_q} == 2'b01);
  assign op_sub = ({mq_q[0], qm1_q} == 2'b10);

  booth_addsub #(.N(W + 2)) u_addsub (
    .sub (op_sub),
    .x   (acc_q),
    .y   ({mcand_q[W], mcand_q}),
    .sum (sum)
  );

  assign acc_new = (op_add || op_sub) ? sum : acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_RUN;
          acc_d   = '0;
          mq_d    = ext_b;
          qm1_d   = 1'b0;
          mcand_d = ext_a;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Arithmetic right shift of {acc, mq, q-1} after the conditional add.
        acc_d = {acc_new[W+1], acc_new[W+1:1]};
        mq_d  = {acc_new[0], mq_q[W:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W)) begin
          state_d   = S_DONE;
          product_d = {acc_d[W-2:0], mq_d};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomised checks of booth_seq_mult at W=4, 8 and 16.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st4 = 0, md4 = 0, rdy4, dn4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;
  logic        st8 = 0, md8 = 0, rdy8, dn8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic        st16 = 0, md16 = 0, rdy16, dn16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  booth_seq_mult #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(md4), .a(a4), .b(b4),
    .product(p4), .ready(rdy4), .done(dn4));
  booth_seq_mult #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(md8), .a(a8), .b(b8),
    .product(p8), .ready(rdy8), .done(dn8));
  booth_seq_mult #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(md16), .a(a16), .b(b16),
    .product(p16), .ready(rdy16), .done(dn16));

  int tests = 0;
  int fails = 0;
  int cur_w = 8;

  logic        rdy_s, dn_s;
  logic [63:0] p_s;
  always_comb begin
    rdy_s = rdy8;
    dn_s  = dn8;
    p_s   = {48'd0, p8};
    if (cur_w == 4) begin
      rdy_s = rdy4; dn_s = dn4; p_s = {56'd0, p4};
    end else if (cur_w == 16) begin
      rdy_s = rdy16; dn_s = dn16; p_s = {32'd0, p16};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic st, input logic md,
                        input logic [31:0] a, input logic [31:0] b);
    case (w)
      4: begin st4 = st; md4 = md; a4 = a[3:0]; b4 = b[3:0]; end
      16: begin st16 = st; md16 = md; a16 = a[15:0]; b16 = b[15:0]; end
      default: begin st8 = st; md8 = md; a8 = a[7:0]; b8 = b[7:0]; end
    endcase
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic md,
                                          input logic [31:0] a, input logic [31:0] b);
    longint mask, av, bv, pr;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (md && a[w-1]) av = av - (longint'(1) << w);
    if (md && b[w-1]) bv = bv - (longint'(1) << w);
    pr = av * bv;
    return 64'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Call at a negedge; returns the product and the accept-to-done cycle count.
  task automatic do_op(input int w, input logic md, input logic [31:0] a,
                       input logic [31:0] b, input bit noise,
                       output logic [63:0] prod, output int lat);
    logic [63:0] p0;
    bit          held;
    cur_w = w;
    lat   = -1;
    prod  = '0;
    held  = 1'b1;
    for (int i = 0; i < 40 && !rdy_s; i++) @(negedge clk);
    if (!rdy_s) chk("ready_timeout", 64'(rdy_s), 64'd1);
    set_in(w, 1'b1, md, a, b);
    @(negedge clk);
    p0 = p_s;
    for (int k = 0; k < w + 8; k++) begin
      if (k > 0) @(negedge clk);
      if (dn_s) begin
        lat  = k + 1;
        prod = p_s;
        break;
      end
      if (p_s !== p0) held = 1'b0;
      if (noise && k < w - 1)
        set_in(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      else
        set_in(w, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    chk("product_held_in_run", 64'(held), 64'd1);
  endtask

  typedef struct {
    logic       md;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] prod;
  int          lat;
  int          n_done;
  logic [7:0]  bb_a[3];
  logic [7:0]  bb_b[3];
  logic [15:0] bb_p[3];

  initial begin
    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[4] = '{1'b1, 8'h00, 8'hB3, 16'h0000};
    vecs[5] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[7] = '{1'b0, 8'hC8, 8'h03, 16'h0258};
    vecs[8] = '{1'b1, 8'hFB, 8'hF9, 16'h0023};
    bb_a = '{8'd3, 8'd7, 8'd2};
    bb_b = '{8'd5, 8'd9, 8'hFE};
    bb_p = '{16'd15, 16'd63, 16'hFFFC};

    repeat (3) @(negedge clk);
    chk("reset_product", 64'(p8), 64'd0);
    chk("reset_ready", 64'(rdy8), 64'd1);
    chk("reset_done", 64'(dn8), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(8, vecs[i].md, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, 1'b0, prod, lat);
      chk($sformatf("vec%0d_product", i), prod, 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd10);
    end

    // Back-to-back: start stays high; new operands presented in each DONE cycle.
    cur_w = 8;
    @(negedge clk);
    n_done = 0;
    set_in(8, 1'b1, 1'b1, {24'd0, bb_a[0]}, {24'd0, bb_b[0]});
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (dn8) begin
        if (n_done < 3) begin
          chk($sformatf("b2b%0d_cycle", n_done), 64'(k), 64'(9 + 10 * n_done));
          chk($sformatf("b2b%0d_product", n_done), 64'(p8), 64'(bb_p[n_done]));
        end
        n_done++;
        if (n_done < 3)
          set_in(8, 1'b1, 1'b1, {24'd0, bb_a[n_done]}, {24'd0, bb_b[n_done]});
        else
          set_in(8, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk("b2b_done_count", 64'(n_done), 64'd3);

    // Reset landing in cycle 4 of a RUN.
    @(negedge clk);
    set_in(8, 1'b1, 1'b0, 32'd9, 32'd9);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dn8) n_done++;
      if (k == 0) set_in(8, 1'b0, 1'b0, 32'd0, 32'd0);
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        chk("abort_done", 64'(dn8), 64'd0);
        chk("abort_ready", 64'(rdy8), 64'd1);
        chk("abort_product", 64'(p8), 64'd0);
        rst = 1'b0;
      end
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    do_op(8, 1'b0, 32'd6, 32'd7, 1'b0, prod, lat);
    chk("after_abort_product", prod, 64'd42);
    chk("after_abort_latency", 64'(lat), 64'd10);

    // Random operands with start noise during RUN, at each width.
    for (int wi = 0; wi < 3; wi++) begin
      int w;
      w = (wi == 0) ? 4 : ((wi == 1) ? 8 : 16);
      for (int r = 0; r < 8; r++) begin
        logic        md;
        logic [31:0] ra, rb;
        md = 1'($urandom_range(0, 1));
        ra = $urandom;
        rb = $urandom;
        @(negedge clk);
        do_op(w, md, ra, rb, 1'b1, prod, lat);
        chk($sformatf("rnd_w%0d_%0d_product", w, r), prod, ref_mul(w, md, ra, rb));
        chk($sformatf("rnd_w%0d_%0d_latency", w, r), 64'(lat), 64'(w + 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
